// File: rtl/tmr_pkg.sv
// Shared definitions for the IEC 61131-3 timer core: timer type codes and
// the clear-sweep FSM state encoding.
package tmr_pkg;

    localparam logic [1:0] TP   = 2'd0;
    localparam logic [1:0] TON  = 2'd1;
    localparam logic [1:0] TOF  = 2'd2;
    localparam logic [1:0] TONR = 2'd3;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } clr_state_e;

endpackage

// File: rtl/tmr_spram.sv
// Single-port RAM with registered read, write-through output register and a
// separate clear-write port used by the reset sweep. Only the output register
// is reset; the array itself is cleared by the sweep.
module tmr_spram #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              en_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              clr_i,
    input  logic [ADDR_W-1:0] clr_addr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem [2**ADDR_W];
    logic [DATA_W-1:0] rdata_q;

    // Array update: sweep clear has priority over a normal write.
    always_ff @(posedge clk_i) begin
        if (clr_i)
            mem[clr_addr_i] <= '0;
        else if (en_i && we_i)
            mem[addr_i] <= wdata_i;
    end

    // Output register: read data, or the written data on a write.
    always_ff @(posedge clk_i) begin
        if (rst_i)
            rdata_q <= '0;
        else if (en_i)
            rdata_q <= we_i ? wdata_i : mem[addr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/tmr_core_ext.sv
// Multi-channel TP/TON/TOF timer core with optional retentive on-delay
// (TONR). Build with TMR_TONR_EN defined to include TONR mode, the
// accumulator memory and the retentive reset; otherwise type 3 acts as TOF.
module tmr_core_ext
    import tmr_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int TIME_W = 32
) (
    input  logic              tmr_clk,
    input  logic              tmr_rst,
    input  logic [ADDR_W-1:0] tmr_addr,
    input  logic              tmr_en,
    input  logic [TIME_W-1:0] tmr_data_in,
    input  logic              tmr_pt_wr,
    input  logic              tmr_in_wr,
    input  logic              tmr_type_wr,
    input  logic              tmr_r_wr,
    input  logic [TIME_W-1:0] tmr_rtc_data_out,
    output logic [TIME_W-1:0] tmr_pt_data_out,
    output logic              tmr_in_data_out,
    output logic [1:0]        tmr_type_data_out,
    output logic [TIME_W-1:0] tmr_et_data_out,
    output logic              tmr_q_data_out,
    output logic              tmr_busy
);

    clr_state_e        state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;

    logic              acc_en, clr, d0, rise, fall, start, lt;
    logic [1:0]        ttype;
    logic [TIME_W-1:0] pt_q, st_q, el, el_min, et;
    logic              in_q, run_q, q;
    logic [1:0]        type_q;
    logic              st_we, run_we, run_wd;

    // Clear FSM state register; reset (re)starts the sweep at address 0.
    always_ff @(posedge tmr_clk) begin
        if (tmr_rst) begin
            state_q <= ST_CLEAR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Clear FSM next state: walk every address once, then return to IDLE.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == ST_CLEAR) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == {ADDR_W{1'b1}})
                state_d = ST_IDLE;
        end
    end

    assign tmr_busy = (state_q == ST_CLEAR);
    assign clr      = tmr_busy;
    assign acc_en   = tmr_en & ~tmr_busy & ~tmr_rst;

    assign d0   = tmr_data_in[0];
    assign rise = d0 & ~in_q;
    assign fall = ~d0 & in_q;

    assign el     = tmr_rtc_data_out - st_q;
    assign lt     = el < pt_q;
    assign el_min = lt ? el : pt_q;

`ifdef TMR_TONR_EN
    logic [TIME_W-1:0] acc_q, acc_fall, tonr_et, acc_wd;
    logic [TIME_W:0]   fall_sum, live_sum;
    logic              acc_we;

    assign ttype    = type_q;
    assign fall_sum = {1'b0, acc_q} + {1'b0, el};
    assign live_sum = {1'b0, acc_q} + (in_q ? {1'b0, el} : '0);
    assign acc_fall = (fall_sum > {1'b0, pt_q}) ? pt_q : fall_sum[TIME_W-1:0];
    assign tonr_et  = (live_sum > {1'b0, pt_q}) ? pt_q : live_sum[TIME_W-1:0];
    assign acc_we   = (tmr_in_wr & fall & run_q & (ttype == TONR)) | (tmr_r_wr & d0);
    assign acc_wd   = tmr_r_wr ? '0 : acc_fall;

    tmr_spram #(.DATA_W(TIME_W), .ADDR_W(ADDR_W)) u_acc (
        .clk_i(tmr_clk), .rst_i(tmr_rst), .en_i(acc_en), .we_i(acc_we),
        .addr_i(tmr_addr), .wdata_i(acc_wd), .clr_i(clr), .clr_addr_i(cnt_q),
        .rdata_o(acc_q));
`else
    assign ttype = (type_q == TONR) ? TOF : type_q;
`endif

    // Per-type ET/Q and start-time condition from registered state and live RTC.
    always_comb begin
        et    = '0;
        q     = 1'b0;
        start = 1'b0;
        case (ttype)
            TP: begin
                q     = lt & run_q;
                et    = (run_q & (lt | in_q)) ? el_min : '0;
                start = rise & ~(lt & run_q);
            end
            TON: begin
                q     = ~lt & in_q & run_q;
                et    = (in_q & run_q) ? el_min : '0;
                start = rise;
            end
`ifdef TMR_TONR_EN
            TONR: begin
                et    = run_q ? tonr_et : '0;
                q     = (tonr_et == pt_q) & run_q;
                start = rise;
            end
`endif
            default: begin
                q     = (in_q | lt) & run_q;
                et    = (run_q & ~in_q) ? el_min : '0;
                start = fall;
            end
        endcase
    end

    assign st_we  = tmr_in_wr & start;
    assign run_we = st_we | (tmr_r_wr & d0);
    assign run_wd = ~tmr_r_wr;

    tmr_spram #(.DATA_W(TIME_W), .ADDR_W(ADDR_W)) u_pt (
        .clk_i(tmr_clk), .rst_i(tmr_rst), .en_i(acc_en), .we_i(tmr_pt_wr),
        .addr_i(tmr_addr), .wdata_i(tmr_data_in), .clr_i(clr), .clr_addr_i(cnt_q),
        .rdata_o(pt_q));

    tmr_spram #(.DATA_W(1), .ADDR_W(ADDR_W)) u_in (
        .clk_i(tmr_clk), .rst_i(tmr_rst), .en_i(acc_en), .we_i(tmr_in_wr),
        .addr_i(tmr_addr), .wdata_i(d0), .clr_i(clr), .clr_addr_i(cnt_q),
        .rdata_o(in_q));

    tmr_spram #(.DATA_W(2), .ADDR_W(ADDR_W)) u_type (
        .clk_i(tmr_clk), .rst_i(tmr_rst), .en_i(acc_en), .we_i(tmr_type_wr),
        .addr_i(tmr_addr), .wdata_i(tmr_data_in[1:0]), .clr_i(clr), .clr_addr_i(cnt_q),
        .rdata_o(type_q));

    tmr_spram #(.DATA_W(1), .ADDR_W(ADDR_W)) u_run (
        .clk_i(tmr_clk), .rst_i(tmr_rst), .en_i(acc_en), .we_i(run_we),
        .addr_i(tmr_addr), .wdata_i(run_wd), .clr_i(clr), .clr_addr_i(cnt_q),
        .rdata_o(run_q));

    tmr_spram #(.DATA_W(TIME_W), .ADDR_W(ADDR_W)) u_st (
        .clk_i(tmr_clk), .rst_i(tmr_rst), .en_i(acc_en), .we_i(st_we),
        .addr_i(tmr_addr), .wdata_i(tmr_rtc_data_out), .clr_i(clr), .clr_addr_i(cnt_q),
        .rdata_o(st_q));

    assign tmr_pt_data_out   = pt_q;
    assign tmr_in_data_out   = in_q;
    assign tmr_type_data_out = type_q;
    assign tmr_et_data_out   = et;
    assign tmr_q_data_out    = q;

endmodule

// File: tb/tb_tmr_core_ext.sv
// Directed bench for tmr_core_ext (ADDR_W=4, TIME_W=32). The TONR section
// follows TMR_TONR_EN; without it, type 3 is exercised as TOF.
module tb_tmr_core_ext;

    localparam int AW = 4;
    localparam int TW = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [AW-1:0] addr = '0;
    logic          en = 1'b0;
    logic [TW-1:0] din = '0;
    logic          pt_wr = 1'b0, in_wr = 1'b0, type_wr = 1'b0, r_wr = 1'b0;
    logic [TW-1:0] rtc = '0;
    logic [TW-1:0] pt_o, et_o;
    logic          in_o, q_o, busy;
    logic [1:0]    type_o;

    int errors = 0;
    int checks = 0;
    int n;

    tmr_core_ext #(.ADDR_W(AW), .TIME_W(TW)) dut (
        .tmr_clk(clk), .tmr_rst(rst), .tmr_addr(addr), .tmr_en(en),
        .tmr_data_in(din), .tmr_pt_wr(pt_wr), .tmr_in_wr(in_wr),
        .tmr_type_wr(type_wr), .tmr_r_wr(r_wr), .tmr_rtc_data_out(rtc),
        .tmr_pt_data_out(pt_o), .tmr_in_data_out(in_o),
        .tmr_type_data_out(type_o), .tmr_et_data_out(et_o),
        .tmr_q_data_out(q_o), .tmr_busy(busy));

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        en = 1'b0; pt_wr = 1'b0; in_wr = 1'b0; type_wr = 1'b0; r_wr = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [TW-1:0] got, input logic [TW-1:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic rd(input logic [AW-1:0] a);
        idle(); addr = a; en = 1'b1;
        tick();
        idle();
    endtask

    task automatic wr(input int kind, input logic [AW-1:0] a, input logic [TW-1:0] v);
        idle(); addr = a; din = v; en = 1'b1;
        case (kind)
            0: pt_wr = 1'b1;
            1: type_wr = 1'b1;
            default: r_wr = 1'b1;
        endcase
        tick();
        idle();
    endtask

    // Executor protocol: read at A, then IN write at A.
    task automatic wr_in(input logic [AW-1:0] a, input logic v);
        rd(a);
        addr = a; din = {{(TW-1){1'b0}}, v}; en = 1'b1; in_wr = 1'b1;
        tick();
        idle();
    endtask

    task automatic count_busy();
        n = 0;
        while (busy && n < 100) begin
            tick();
            n++;
        end
    endtask

    initial begin
        #1;
        // Reset and first sweep
        rst = 1'b1; tick(); rst = 1'b0;
        chk("rst_busy", {31'b0, busy}, 1);
        chk("rst_pt", pt_o, 0);
        chk("rst_in", {31'b0, in_o}, 0);
        chk("rst_type", {30'b0, type_o}, 0);
        chk("rst_et", et_o, 0);
        chk("rst_q", {31'b0, q_o}, 0);
        count_busy();
        chk("sweep_len", n, 16);
        rd(4'd9);
        chk("clr_pt", pt_o, 0);
        chk("clr_type", {30'b0, type_o}, 0);
        chk("clr_et", et_o, 0);
        chk("clr_q", {31'b0, q_o}, 0);

        // TON, PT=100
        wr(0, 4'd1, 100);
        chk("wt_pt", pt_o, 100);
        wr(1, 4'd1, 1);
        chk("wt_type", {30'b0, type_o}, 1);
        rtc = 1000; wr_in(4'd1, 1'b1);
        chk("ton_in", {31'b0, in_o}, 1);
        rtc = 1050; #1;
        chk("ton_et50", et_o, 50);
        chk("ton_q50", {31'b0, q_o}, 0);
        rtc = 1100; #1;
        chk("ton_et100", et_o, 100);
        chk("ton_q100", {31'b0, q_o}, 1);
        rtc = 1300; #1;
        chk("ton_sat", et_o, 100);
        wr_in(4'd1, 1'b0);
        chk("ton_off_et", et_o, 0);
        chk("ton_off_q", {31'b0, q_o}, 0);

        // TP across RTC wrap, PT=20
        wr(0, 4'd2, 20);
        wr(1, 4'd2, 0);
        rtc = 32'hFFFF_FFF6; wr_in(4'd2, 1'b1);
        rtc = 32'h0000_0005; #1;
        chk("tp_wrap_et", et_o, 15);
        chk("tp_wrap_q", {31'b0, q_o}, 1);
        rtc = 32'h0000_000A; #1;
        chk("tp_end_et", et_o, 20);
        chk("tp_end_q", {31'b0, q_o}, 0);

        // Type 3 timer, PT=100
        wr(0, 4'd3, 100);
        wr(1, 4'd3, 3);
        chk("t3_type", {30'b0, type_o}, 3);
`ifdef TMR_TONR_EN
        rtc = 2000; wr_in(4'd3, 1'b1);
        rtc = 2030; wr_in(4'd3, 1'b0);
        rtc = 2070; #1;
        chk("tonr_hold_et", et_o, 30);
        chk("tonr_hold_q", {31'b0, q_o}, 0);
        rtc = 2080; wr_in(4'd3, 1'b1);
        rtc = 2120; #1;
        chk("tonr_et70", et_o, 70);
        chk("tonr_q70", {31'b0, q_o}, 0);
        rtc = 2150; #1;
        chk("tonr_et100", et_o, 100);
        chk("tonr_q100", {31'b0, q_o}, 1);
        wr(2, 4'd3, 1);
        chk("tonr_r_et", et_o, 0);
        chk("tonr_r_q", {31'b0, q_o}, 0);
`else
        rtc = 2000; wr_in(4'd3, 1'b1);
        chk("tof_on_q", {31'b0, q_o}, 0);
        rtc = 2010; wr_in(4'd3, 1'b0);
        rtc = 2050; #1;
        chk("tof_et40", et_o, 40);
        chk("tof_q40", {31'b0, q_o}, 1);
        rtc = 2120; #1;
        chk("tof_et_end", et_o, 100);
        chk("tof_q_end", {31'b0, q_o}, 0);
        rtc = 2050; #1;
        wr(2, 4'd3, 1);
        chk("tof_r_q", {31'b0, q_o}, 0);
`endif

        // tmr_en=0 holds output registers
        rd(4'd1);
        addr = 4'd5; en = 1'b0; tick();
        chk("en0_hold", pt_o, 100);

        // Reset during sweep, and an access while busy
        rst = 1'b1; tick(); rst = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        chk("mid_busy", {31'b0, busy}, 1);
        rst = 1'b1; tick(); rst = 1'b0;
        n = 0;
        while (busy && n < 100) begin
            if (n == 5) begin
                addr = 4'd1; din = 55; en = 1'b1; pt_wr = 1'b1;
            end else begin
                idle();
            end
            tick();
            n++;
        end
        idle();
        chk("resweep_len", n, 16);
        chk("busy_hold_pt", pt_o, 0);
        rd(4'd1);
        chk("busy_wr_drop", pt_o, 0);
        rd(4'd3);
        chk("resweep_type", {30'b0, type_o}, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/tmr_core_ext.md
# tmr_core_ext

Parametrised, multi-channel IEC 61131-3 timer core for the PLC's timer instruction unit. It holds per-timer preset, start time, input, type, run and accumulator state in address-indexed memories, all driven by a single shared RTC value. It extends the existing TP/TON/TOF core with three additions: a configurable time width, a retentive on-delay (TONR) mode with reset, and a synchronous reset that clears all timer memories. It sits between the instruction executor and the RTC, with one timer accessed per cycle.

## Interface
- ADDR_W, 8: timer index width; 2**ADDR_W timers.
- TIME_W, 32: width of PT, ET, RTC, start time and accumulator.

- tmr_clk  in  1  clock.
- tmr_rst  in  1  synchronous, active-high reset.
- tmr_addr  in  ADDR_W  timer index.
- tmr_en  in  1  access enable; ignored while tmr_busy=1.
- tmr_data_in  in  TIME_W  write data: PT, IN in bit 0, type in bits [1:0], R in bit 0.
- tmr_pt_wr / tmr_in_wr / tmr_type_wr / tmr_r_wr  in  1 each  write strobes. At most one strobe is asserted per cycle.
- tmr_rtc_data_out  in  TIME_W  free-running RTC; wraps modulo 2**TIME_W.
- tmr_pt_data_out  out  TIME_W  preset of the last accessed timer.
- tmr_in_data_out  out  1  IN of the last accessed timer.
- tmr_type_data_out  out  2  type of the last accessed timer.
- tmr_et_data_out  out  TIME_W  elapsed time.
- tmr_q_data_out  out  1  timer output Q.
- tmr_busy  out  1  clear sweep in progress.

## Operation
- Type codes: TP=0, TON=1, TOF=2, TONR=3.
- Memories are single-port, with a registered read. A write also updates the output register with the written data (write-through).
- The executor uses a read-then-write protocol:
  - Cycle n: read at address A.
  - Cycle n+1: tmr_in_wr at address A.
  - Edges are computed from tmr_data_in[0] against the registered in_data_out.
- Start-time write (st := RTC) happens on tmr_in_wr when:
  - TP: rising edge and Q=0.
  - TON: rising edge.
  - TONR: rising edge.
  - TOF: falling edge.
- run := run OR (start-time write condition) on tmr_in_wr. run is cleared only by reset or by R.
- Elapsed time: el = (RTC − st) mod 2**TIME_W, computed as unsigned TIME_W-bit subtraction. Exactly one wrap is tolerated.
- TP, TON and TOF keep the existing semantics:
  - Et = min(el, PT), masked per type.
  - TP: Q = (el<PT)&run.
  - TON: Q = (el≥PT)&IN&run.
  - TOF: Q = (IN|(el<PT))&run.
- TONR:
  - On a falling edge (tmr_in_wr): acc := min(acc + el, PT), using a saturating TIME_W+1-bit add.
  - ET = min(acc + (IN ? el : 0), PT).
  - Q = (ET == PT) & run.
  - ET and Q hold while IN=0.
- tmr_r_wr with data bit 0 = 1: acc := 0, run := 0. Outputs are ET=0 and Q=0 from the next cycle. It has no effect on non-TONR timers except clearing run.
- Clear FSM states:
  - CLEAR: counter walks addresses 0 → 2**ADDR_W−1, writing PT=0, type=TP, IN=0, run=0, st=0 and acc=0. tmr_busy=1.
  - IDLE: normal access. tmr_busy=0.
  - Transitions: tmr_rst → CLEAR with counter=0. Last address → IDLE.
  - tmr_rst during CLEAR restarts the sweep at 0.

## Timing
- Reset values, from the cycle after tmr_rst: all output registers 0, so pt=0, in=0, type=TP, et=0, q=0. tmr_busy=1.
- The clear sweep lasts 2**ADDR_W cycles. tmr_busy falls on the cycle after the write to the last address.
- Read latency is 1 cycle. ET and Q are combinational from the registered outputs and the live RTC.
- Write-through: written data appears on outputs 1 cycle after the strobe.
- tmr_en=0 holds all output registers.
- Simultaneous tmr_rst and access: reset wins; the access is dropped.

## Configuration
- TMR_TONR_EN defined:
  - TONR mode, the acc memory and tmr_r_wr are built.
- Undefined:
  - The acc memory is not instantiated.
  - Type 3 decodes as TOF.
  - tmr_r_wr clears run only.

## Structure
- Shared package tmr_pkg holds:
  - Type localparams TP/TON/TOF/TONR.
  - Clear FSM state encoding.
- One sub-module, tmr_spram (parameters DATA_W, ADDR_W): single-port write-through RAM with a synchronous clear-write port, instantiated once per memory.

## Test plan
- Reset sweep, ADDR_W=4:
  - tmr_rst for 1 cycle → tmr_busy=1 for 16 cycles, then 0.
  - Read of any timer → PT=0, type=0, ET=0, Q=0.
- TON, PT=100, RTC=1000:
  - IN rising at RTC=1000.
  - At RTC=1050 → ET=50, Q=0.
  - At RTC=1100 → ET=100, Q=1.
  - IN=0 → ET=0, Q=0.
- Wrap, TIME_W=32, TP, PT=20:
  - Start at RTC=0xFFFF_FFF6.
  - At RTC=0x0000_0005 → ET=15, Q=1.
  - At RTC=0x0000_000A → ET=20, Q=0.
- TONR, PT=100:
  - IN high for 30 ticks, low for 50, high again for 40 → ET=70, Q=0.
  - A further 30 ticks high → ET=100, Q=1.
  - R=1 → ET=0, Q=0.
- Reset during sweep:
  - tmr_rst again at sweep address 7 → sweep restarts at 0; tmr_busy stays high for 16 more cycles.
  - An access attempted while busy is ignored: a PT write is not stored.
